// File: rtl/digit_scan_controller.sv
// Keypad digit entry buffer plus scan sequencer that time-shares one BCD-to-segment
// decoder across NUM_DIGITS positions, with a one-cycle blanking gap between slots.
module digit_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [3:0]            in_digit,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [3:0]            dig_code,
    output logic                  dec_ready,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic [3:0]            count,
    output logic                  reject
);

    localparam int              IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              DW       = $clog2(SCAN_DIV);
    localparam logic [3:0]      FULL     = 4'(NUM_DIGITS);
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 2);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                      state;
    logic [IW-1:0]               idx;
    logic [IW-1:0]               nxt_idx;
    logic [IW-1:0]               blank_idx;
    logic [DW-1:0]               div;
    logic [3:0]                  scan_cnt;
    logic                        wrap;
    logic                        xfer;
    logic                        take;
    logic                        bad;
    logic [NUM_DIGITS-1:0][3:0]  ent_q;
    logic [NUM_DIGITS-1:0][3:0]  ent_d;
    logic [NUM_DIGITS-1:0]       sel_idx;

    assign in_ready = (count < FULL) & ~clear;
    assign xfer     = in_valid & in_ready;
    assign take     = xfer & (in_digit <= 4'd9);
    assign bad      = xfer & (in_digit > 4'd9);

    // Per-position shift cell and select decode; newest digit enters at position 0.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_pos
        if (i == 0) begin : g_head
            assign ent_d[i] = clear ? 4'd0 : (take ? in_digit : ent_q[i]);
        end else begin : g_tail
            assign ent_d[i] = clear ? 4'd0 : (take ? ent_q[i-1] : ent_q[i]);
        end
        assign sel_idx[i] = (idx == IW'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ent_q <= '0;
        else       ent_q <= ent_d;
    end

    // scan_cnt is the rotation length latched at each wrap, so growth never
    // disturbs the rotation in progress.
    assign wrap      = (idx == IW'(scan_cnt - 4'd1));
    assign nxt_idx   = wrap ? '0 : idx + IW'(1);
    assign blank_idx = (state == SHOW) ? nxt_idx : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            div       <= '0;
            scan_cnt  <= '0;
            count     <= '0;
            reject    <= 1'b0;
            dig_code  <= '0;
            dec_ready <= 1'b0;
            dig_sel   <= '0;
        end else begin
            reject <= bad;
            if (take) count <= count + 4'd1;

            if (clear) begin
                count     <= '0;
                state     <= IDLE;
                idx       <= '0;
                div       <= '0;
                dig_code  <= '0;
                dec_ready <= 1'b0;
                dig_sel   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        idx       <= '0;
                        div       <= '0;
                        dec_ready <= 1'b0;
                        dig_sel   <= '0;
                        dig_code  <= '0;
                        if (count != 4'd0) begin
                            state    <= BLANK;
                            scan_cnt <= count;
                            dig_code <= ent_d[blank_idx];
                        end
                    end
                    BLANK: begin
                        state     <= SHOW;
                        div       <= '0;
                        dec_ready <= 1'b1;
                        dig_sel   <= sel_idx;
                    end
                    SHOW: begin
                        // Code is latched on slot entry and held for the whole slot.
                        if (div == DIV_LAST) begin
                            state     <= BLANK;
                            div       <= '0;
                            idx       <= nxt_idx;
                            dec_ready <= 1'b0;
                            dig_sel   <= '0;
                            dig_code  <= ent_d[blank_idx];
                            if (wrap) scan_cnt <= count;
                        end else begin
                            div <= div + DW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Scoreboard bench for digit_scan_controller: a buffer model predicts handshake
// results and scan slots, which are queued and compared as the DUT produces them.
module tb_digit_scan_controller;

    localparam int N  = 4;
    localparam int SD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [3:0]   in_digit = 4'd0;
    logic         clear = 1'b0;
    logic         in_ready;
    logic [3:0]   dig_code;
    logic         dec_ready;
    logic [N-1:0] dig_sel;
    logic [3:0]   count;
    logic         reject;

    digit_scan_controller #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(in_ready), .clear(clear), .dig_code(dig_code),
        .dec_ready(dec_ready), .dig_sel(dig_sel), .count(count), .reject(reject)
    );

    always #5 clk = ~clk;

    typedef struct { logic [N-1:0] sel; logic [3:0] code; } slot_t;
    typedef struct { logic rej; logic [3:0] cnt; } hs_t;

    slot_t      slot_q[$];
    hs_t        hs_q[$];
    logic [3:0] m_buf[N];
    int         m_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_buf[i] = 4'd0;
    endtask

    task automatic send(input logic [3:0] d);
        hs_t e;
        in_valid = 1'b1;
        in_digit = d;
        e.rej = 1'b0;
        if (m_cnt < N) begin
            if (d <= 4'd9) begin
                for (int i = N - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                m_buf[0] = d;
                m_cnt++;
            end else begin
                e.rej = 1'b1;
            end
        end
        e.cnt = 4'(m_cnt);
        hs_q.push_back(e);
        tick;
        in_valid = 1'b0;
        e = hs_q.pop_front();
        vectors++;
        if (reject !== e.rej) begin
            miscompares++;
            $display("FAIL reject_after_%0d: got %0b want %0b", d, reject, e.rej);
        end
        vectors++;
        if (count !== e.cnt) begin
            miscompares++;
            $display("FAIL count_after_%0d: got %0d want %0d", d, count, e.cnt);
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        model_clear();
        vectors++;
        if (count !== 4'd0 || dig_sel !== '0 || dec_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_idle: count %0d sel %b rdy %b want 0 0 0", count, dig_sel, dec_ready);
        end
    endtask

    task automatic push_rotation(input int n);
        slot_t e;
        for (int k = 0; k < n; k++) begin
            int ix;
            ix = k % m_cnt;
            e.sel = '0;
            e.sel[ix] = 1'b1;
            e.code = m_buf[ix];
            slot_q.push_back(e);
        end
    endtask

    // Skip the slot in progress, optionally sync to position 0, then check n slots.
    task automatic run_slots(input int n, input bit sync0);
        slot_t e;
        int    w;
        int    len;
        bit    ok;
        w = 0;
        while (dec_ready === 1'b1 && w < 4 * SD) begin tick; w++; end
        ok = 1'b0;
        w = 0;
        while (!ok && w < 20 * SD) begin
            if (dec_ready === 1'b1 && (!sync0 || dig_sel[0] === 1'b1)) ok = 1'b1;
            else begin tick; w++; end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL scan_start: no SHOW slot within %0d cycles", 20 * SD);
            slot_q.delete();
            return;
        end
        for (int s = 0; s < n; s++) begin
            if (s > 0) begin
                w = 0;
                while (dec_ready !== 1'b1 && w < 2 * SD) begin tick; w++; end
            end
            e = slot_q.pop_front();
            vectors++;
            if (dig_sel !== e.sel) begin
                miscompares++;
                $display("FAIL slot%0d_sel: got %b want %b", s, dig_sel, e.sel);
            end
            vectors++;
            if (dig_code !== e.code) begin
                miscompares++;
                $display("FAIL slot%0d_code: got %0d want %0d", s, dig_code, e.code);
            end
            len = 1;
            while (dec_ready === 1'b1 && len < 2 * SD) begin
                tick;
                if (dec_ready === 1'b1) len++;
            end
            vectors++;
            if (len != SD - 1) begin
                miscompares++;
                $display("FAIL slot%0d_show_len: got %0d want %0d", s, len, SD - 1);
            end
            vectors++;
            if (dig_sel !== '0) begin
                miscompares++;
                $display("FAIL slot%0d_blank_sel: got %b want 0", s, dig_sel);
            end
        end
    endtask

    task automatic test_reset;
        model_clear();
        tick;
        vectors++;
        if (dig_sel !== '0 || dec_ready !== 1'b0 || count !== 4'd0 || dig_code !== 4'd0 || reject !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: sel %b rdy %b cnt %0d code %0d rej %b want zeros",
                     dig_sel, dec_ready, count, dig_code, reject);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single;
        send(4'd7);
        vectors++;
        if (dig_sel !== '0 || dec_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: sel %b rdy %b want 0 0", dig_sel, dec_ready);
        end
        tick;
        vectors++;
        if (dig_sel !== '0 || dec_ready !== 1'b0 || dig_code !== 4'd7) begin
            miscompares++;
            $display("FAIL single_blank: sel %b rdy %b code %0d want 0 0 7", dig_sel, dec_ready, dig_code);
        end
        push_rotation(2);
        run_slots(2, 1'b1);
    endtask

    task automatic test_full;
        do_clear();
        send(4'd1);
        send(4'd2);
        send(4'd3);
        send(4'd4);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_in_ready: got %b want 0", in_ready);
        end
        send(4'd5);
        push_rotation(5);
        run_slots(5, 1'b1);
    endtask

    task automatic test_reject;
        do_clear();
        send(4'd6);
        send(4'd8);
        send(4'd10);
        tick;
        vectors++;
        if (reject !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_pulse_10: got %b want 0 one cycle later", reject);
        end
        send(4'd15);
        tick;
        vectors++;
        if (reject !== 1'b0 || count !== 4'd2) begin
            miscompares++;
            $display("FAIL reject_pulse_15: rej %b cnt %0d want 0 2", reject, count);
        end
        push_rotation(3);
        run_slots(3, 1'b1);
    endtask

    task automatic test_clear_collision;
        int w;
        w = 0;
        while (dec_ready !== 1'b1 && w < 4 * SD) begin tick; w++; end
        vectors++;
        if (dec_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_pre_show: rdy %b want 1", dec_ready);
        end
        in_valid = 1'b1;
        in_digit = 4'd3;
        clear = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_in_ready: got %b want 0", in_ready);
        end
        tick;
        clear = 1'b0;
        in_valid = 1'b0;
        model_clear();
        vectors++;
        if (count !== 4'd0 || dig_sel !== '0 || dec_ready !== 1'b0 || dig_code !== 4'd0 || reject !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_outputs: cnt %0d sel %b rdy %b code %0d rej %b want zeros",
                     count, dig_sel, dec_ready, dig_code, reject);
        end
        repeat (3) tick;
        vectors++;
        if (count !== 4'd0 || dig_sel !== '0) begin
            miscompares++;
            $display("FAIL collide_stay_idle: cnt %0d sel %b want 0 0", count, dig_sel);
        end
    endtask

    task automatic test_growth;
        int w;
        send(4'd5);
        send(4'd2);
        w = 0;
        while (!(dec_ready === 1'b1 && dig_sel === 4'b0010) && w < 20 * SD) begin tick; w++; end
        send(4'd9);
        vectors++;
        if (dig_sel !== 4'b0010 || dec_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL growth_slot_kept: sel %b rdy %b want 0010 1", dig_sel, dec_ready);
        end
        push_rotation(4);
        run_slots(4, 1'b0);
    endtask

    task automatic test_reset_mid_show;
        int w;
        w = 0;
        while (dec_ready !== 1'b1 && w < 4 * SD) begin tick; w++; end
        reset = 1'b1;
        #2;
        model_clear();
        vectors++;
        if (dig_sel !== '0 || dec_ready !== 1'b0 || count !== 4'd0 || dig_code !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: sel %b rdy %b cnt %0d code %0d want zeros",
                     dig_sel, dec_ready, count, dig_code);
        end
        tick;
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
        repeat (3) tick;
        vectors++;
        if (dig_sel !== '0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: sel %b cnt %0d want 0 0", dig_sel, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_reject();
        test_clear_collision();
        test_growth();
        test_reset_mid_show();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
